// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - MEM_ACCESS_* : access-size encodings, identical to the ones in const.v
//   - RSP_ERR_*    : response error codes returned to writeback
//   - ST_*         : FSM state constants
//   - req_t        : one registered memory request from execute
package lsu_pkg;

  localparam logic [1:0] MEM_ACCESS_BYTE     = 2'd0;
  localparam logic [1:0] MEM_ACCESS_HALFWORD = 2'd1;
  localparam logic [1:0] MEM_ACCESS_WORD     = 2'd2;

  localparam logic [1:0] RSP_ERR_NONE       = 2'd0;
  localparam logic [1:0] RSP_ERR_MISALIGNED = 2'd1;
  localparam logic [1:0] RSP_ERR_ACCESS     = 2'd2;

  localparam int TAG_W = 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_LOAD_ISSUE  = 3'd1;
  localparam state_t ST_LOAD_WAIT   = 3'd2;
  localparam state_t ST_STORE_ISSUE = 3'd3;
  localparam state_t ST_STORE_HOLD  = 3'd4;

  typedef struct packed {
    logic             we;
    logic [1:0]       acc;
    logic             sext;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] tag;
  } req_t;

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundles the execute-side request, the writeback response and the
// mem_control read/write ports of the LSU.
//   slave  : the LSU's view (drives req_ready_o, rsp_*, mem_* controls)
//   master : the surrounding pipeline / mem_control view
interface lsu_if;
  import lsu_pkg::*;

  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [1:0]       req_acc_i;
  logic             req_sext_i;
  logic [31:0]      req_addr_i;
  logic [31:0]      req_wdata_i;
  logic [TAG_W-1:0] req_tag_i;

  logic             rsp_valid_o;
  logic [31:0]      rsp_data_o;
  logic [1:0]       rsp_err_o;
  logic [TAG_W-1:0] rsp_tag_o;

  logic             mem_sext_o;
  logic             mem_r_en_o;
  logic [1:0]       mem_acc_r_o;
  logic [31:0]      mem_addr_r_o;
  logic [31:0]      mem_data_r_i;

  logic             mem_wr_en_o;
  logic [1:0]       mem_acc_w_o;
  logic [31:0]      mem_addr_w_o;
  logic [31:0]      mem_data_w_o;
  logic             mem_wr_ready_i;

  modport slave (
    input  req_valid_i, req_we_i, req_acc_i, req_sext_i, req_addr_i,
           req_wdata_i, req_tag_i, mem_data_r_i, mem_wr_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_tag_o,
           mem_sext_o, mem_r_en_o, mem_acc_r_o, mem_addr_r_o,
           mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o
  );

  modport master (
    output req_valid_i, req_we_i, req_acc_i, req_sext_i, req_addr_i,
           req_wdata_i, req_tag_i, mem_data_r_i, mem_wr_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_tag_o,
           mem_sext_o, mem_r_en_o, mem_acc_r_o, mem_addr_r_o,
           mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o
  );

endinterface

// File: rtl/lsu_check.sv
// lsu_check: combinational alignment and address-range check.
//   acc  in  2   access size (MEM_ACCESS_*)
//   addr in  32  byte address
//   err  out 2   RSP_ERR_* code; misalignment takes priority over range
module lsu_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] MAP_ZERO = 32'h0,
  parameter int unsigned ROWS     = 512
) (
  input  logic [1:0]  acc,
  input  logic [31:0] addr,
  output logic [1:0]  err
);

  localparam logic [32:0] WIN_SIZE = 33'(ROWS) * 33'd4;

  logic        misaligned;
  logic        in_range;
  logic [32:0] offset;

  // Offset from the window base in 33 bits: bit 32 set means addr < MAP_ZERO,
  // so a single unsigned compare covers both ends of the window.
  always_comb begin
    misaligned = ((acc == MEM_ACCESS_HALFWORD) && addr[0]) ||
                 ((acc == MEM_ACCESS_WORD) && (addr[1:0] != 2'b00));
    offset     = {1'b0, addr} - {1'b0, MAP_ZERO};
    in_range   = !offset[32] && (offset < WIN_SIZE);
    if (misaligned)
      err = RSP_ERR_MISALIGNED;
    else if (!in_range)
      err = RSP_ERR_ACCESS;
    else
      err = RSP_ERR_NONE;
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and mem_control.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : request from execute (req_*), one-cycle response pulse to
//                  writeback (rsp_*), mem_control one-cycle read port
//                  (mem_*_r) and two-cycle read-modify-write port (mem_*_w)
// One request in flight at a time; faults are answered the cycle after
// accept without touching memory.
module lsu
  import lsu_pkg::*;
#(
  parameter logic [31:0] MAP_ZERO = 32'h0,
  parameter int unsigned ROWS     = 512
) (
  input  logic  clk_i,
  input  logic  rst_i,
  lsu_if.slave  bus
);

  state_t           state_q;
  req_t             req;
  logic             accept;
  logic [1:0]       chk_err;

  logic [TAG_W-1:0] tag_q;
  logic [31:0]      rd_addr_q;
  logic [1:0]       rd_acc_q;
  logic             rd_sext_q;
  logic [31:0]      wr_addr_q;
  logic [1:0]       wr_acc_q;
  logic [31:0]      wr_data_q;

  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;
  logic [1:0]       rsp_err_q;
  logic [TAG_W-1:0] rsp_tag_q;

  always_comb begin
    req.we    = bus.req_we_i;
    req.acc   = bus.req_acc_i;
    req.sext  = bus.req_sext_i;
    req.addr  = bus.req_addr_i;
    req.wdata = bus.req_wdata_i;
    req.tag   = bus.req_tag_i;
  end

  assign accept = bus.req_valid_i && (state_q == ST_IDLE);

  lsu_check #(
    .MAP_ZERO (MAP_ZERO),
    .ROWS     (ROWS)
  ) u_check (
    .acc  (req.acc),
    .addr (req.addr),
    .err  (chk_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tag_q       <= '0;
      rd_addr_q   <= '0;
      rd_acc_q    <= '0;
      rd_sext_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= RSP_ERR_NONE;
      rsp_tag_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tag_q <= req.tag;
            if (chk_err != RSP_ERR_NONE) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= chk_err;
              rsp_data_q  <= '0;
              rsp_tag_q   <= req.tag;
            end else if (req.we) begin
              state_q <= ST_STORE_ISSUE;
            end else begin
              state_q   <= ST_LOAD_ISSUE;
              rd_addr_q <= req.addr;
              rd_acc_q  <= req.acc;
              rd_sext_q <= req.sext;
            end
          end
        end
        ST_LOAD_ISSUE: state_q <= ST_LOAD_WAIT;
        ST_LOAD_WAIT: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= RSP_ERR_NONE;
          rsp_data_q  <= bus.mem_data_r_i;
          rsp_tag_q   <= tag_q;
        end
        ST_STORE_ISSUE: begin
          if (bus.mem_wr_ready_i)
            state_q <= ST_STORE_HOLD;
        end
        ST_STORE_HOLD: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= RSP_ERR_NONE;
          rsp_data_q  <= '0;
          rsp_tag_q   <= tag_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Deliberately not reset: mem_control commits from these during
  // ST_STORE_HOLD, and a reset in that cycle must not redirect the commit.
  always_ff @(posedge clk_i) begin
    if (accept && req.we && (chk_err == RSP_ERR_NONE)) begin
      wr_addr_q <= req.addr;
      wr_acc_q  <= req.acc;
      wr_data_q <= req.wdata;
    end
  end

  assign bus.req_ready_o  = (state_q == ST_IDLE);

  // The read enable stays low in both store states because mem_control
  // borrows its read port for the merge.
  assign bus.mem_r_en_o   = (state_q == ST_LOAD_ISSUE);
  assign bus.mem_addr_r_o = rd_addr_q;
  assign bus.mem_acc_r_o  = rd_acc_q;
  assign bus.mem_sext_o   = rd_sext_q;

  assign bus.mem_wr_en_o  = (state_q == ST_STORE_ISSUE);
  assign bus.mem_addr_w_o = wr_addr_q;
  assign bus.mem_acc_w_o  = wr_acc_q;
  assign bus.mem_data_w_o = wr_data_q;

  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.rsp_err_o    = rsp_err_q;
  assign bus.rsp_tag_o    = rsp_tag_q;

endmodule
